mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-stage consumer of execute-stage results: ALU/address result, store data pre-positioned by byte lane, and load/store/byte control.
- Runs a handshaked request/response transaction with the data memory, extracts and zero-extends load bytes, and presents one result per instruction to writeback through a one-entry output buffer.
- Stalls the upstream pipeline while a memory access is outstanding or the output buffer is occupied.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ACCESS without dmem_resp before abort; 0 disables timeout
CNT_WIDTH, 8, width of wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  execute stage presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_result  input  16  execute ALU/mux result (lc3b_word); effective address for memory ops
in_wdata  input  16  store data, already shifted to the correct byte lane
in_mem_read  input  1  load instruction
in_mem_write  input  1  store instruction; never set together with in_mem_read
in_mem_byte  input  1  byte-sized access (LDB/STB)
dmem_address  output  16  word-aligned memory address
dmem_read  output  1  read request
dmem_write  output  1  write request
dmem_byte_enable  output  2  lane enables {hi,lo}
dmem_wdata  output  16  write data
dmem_rdata  input  16  read data, valid with dmem_resp
dmem_resp  input  1  single-cycle completion pulse
out_valid  output  1  result available to writeback
out_ready  input  1  writeback consumes result
out_data  output  16  result word
out_err  output  1  result is from misaligned or timed-out access

Behaviour:
- Reset (async, active-high): state IDLE, counter 0. All outputs are 0 except in_ready, which is 1. An outstanding request is dropped immediately.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- States: IDLE, ACCESS.
- Non-memory op accepted:
  - Next edge loads out_data=in_result, out_err=0, out_valid=1.
  - Latency 1. Back-to-back throughput 1 per cycle when out_ready=1.
- Misaligned word op (mem op, !in_mem_byte, in_result[0]=1):
  - No memory request is issued.
  - Next edge loads out_data=16'h0000, out_err=1, out_valid=1.
- Aligned memory op accepted:
  - Register address, wdata, byte flag, low address bit and direction. Go to ACCESS; counter cleared.
- ACCESS outputs:
  - dmem_read or dmem_write held high continuously until the cycle dmem_resp=1 (inclusive), then low.
  - dmem_address={addr[15:1],1'b0}. dmem_wdata=registered wdata.
  - dmem_byte_enable=2'b11 for word; 2'b10 if byte and addr[0]=1; 2'b01 if byte and addr[0]=0. Value also driven during reads.
- dmem_resp in ACCESS: next edge returns to IDLE and loads the out register.
  - Load word: out_data=dmem_rdata.
  - Load byte: out_data={8'h00, addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]}.
  - Store: out_data=registered in_result.
  - out_err=0. Minimum accept-to-out_valid latency is 2 cycles (resp in first ACCESS cycle).
- Timeout (TIMEOUT_CYCLES>0):
  - Counter increments each ACCESS cycle without resp.
  - When it reaches TIMEOUT_CYCLES, the request deasserts and the stage returns to IDLE with out_data=0, out_err=1, out_valid=1.
  - dmem_resp in the same cycle as the timeout wins; the access completes normally.
- dmem_resp outside ACCESS is ignored.
- Output buffer:
  - out_valid/out_data/out_err are held stable while out_valid && !out_ready.
  - out_valid clears on an out_ready edge unless a new result loads the same edge.
  - Simultaneous consume and load is allowed; the new value wins.
- in_ready is 0 for the whole ACCESS state, including the resp cycle.
- Widths: all data 16-bit; no arithmetic beyond the counter, which saturates and never wraps.

Test Plan:
- Non-memory: in_result=16'h1234, out_ready=1 -> out_valid next cycle, out_data=16'h1234, out_err=0; 3 back-to-back ops retire 1/cycle.
- LDB odd: addr 16'h3001, dmem_rdata=16'hABCD after 3 wait cycles -> dmem_address=16'h3000, byte_enable=2'b10, read held 4 cycles, out_data=16'h00AB; even addr 16'h3000 -> 16'h00CD.
- STB/STW: STB addr 16'h0041, wdata 16'h5500 -> dmem_write, byte_enable=2'b10, dmem_wdata=16'h5500; STW addr 16'h0042 -> byte_enable=2'b11, out_data=16'h0042.
- Misaligned LDW addr 16'h0005 -> no dmem_read ever asserted, out_err=1, out_data=0 one cycle later.
- Timeout TIMEOUT_CYCLES=4, no resp -> request high exactly 4 cycles, then out_err=1; repeat with resp on cycle 4 -> normal completion, out_err=0.
- Backpressure/reset: out_ready=0 holds out_data stable and in_ready=0 for 5 cycles; reset asserted mid-ACCESS -> dmem_read=0, out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage: issues handshaked dmem accesses, extracts load bytes, buffers one result for writeback.
// Latency 1 (non-mem/misaligned) or 2+ (memory); in_ready drops while an access is outstanding or the buffer is held.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_result,
   input  logic [15:0] in_wdata,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic        in_mem_byte,
   output logic [15:0] dmem_address,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [1:0]  dmem_byte_enable,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_err
);

   typedef enum logic {IDLE, ACCESS} state_t;

   // Last counter value before abort; unused when the timeout is disabled.
   localparam logic [CNT_WIDTH-1:0] TO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [15:0]          addr_q;
   logic [15:0]          wdata_q;
   logic                 byte_q;
   logic                 write_q;

   logic                 active;
   logic                 accept;
   logic                 is_mem;
   logic                 misaligned;
   logic                 timed_out;
   logic [15:0]          resp_data;

   assign active     = (state == ACCESS);
   assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign is_mem     = in_mem_read || in_mem_write;
   assign misaligned = is_mem && !in_mem_byte && in_result[0];
   assign timed_out  = (TIMEOUT_CYCLES != 0) && active && !dmem_resp && (cnt == TO_LAST);

   assign dmem_read        = active && !write_q;
   assign dmem_write       = active && write_q;
   assign dmem_address     = active ? {addr_q[15:1], 1'b0} : 16'h0000;
   assign dmem_wdata       = active ? wdata_q : 16'h0000;
   assign dmem_byte_enable = !active ? 2'b00 :
                             !byte_q ? 2'b11 :
                             addr_q[0] ? 2'b10 : 2'b01;

   always_comb begin
      resp_data = dmem_rdata;
      if (write_q)
         resp_data = addr_q;
      else if (byte_q)
         resp_data = {8'h00, addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         byte_q    <= 1'b0;
         write_q   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 16'h0000;
         out_err   <= 1'b0;
      end else begin
         // Consume first; a result loaded this same edge overrides it.
         if (out_ready)
            out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!is_mem || misaligned) begin
                     out_valid <= 1'b1;
                     out_data  <= misaligned ? 16'h0000 : in_result;
                     out_err   <= misaligned;
                  end else begin
                     state   <= ACCESS;
                     cnt     <= '0;
                     addr_q  <= in_result;
                     wdata_q <= in_wdata;
                     byte_q  <= in_mem_byte;
                     write_q <= in_mem_write;
                  end
               end
            end
            ACCESS: begin
               if (dmem_resp) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  out_data  <= resp_data;
                  out_err   <= 1'b0;
               end else if (timed_out) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  out_data  <= 16'h0000;
                  out_err   <= 1'b1;
               end else if (cnt != '1) begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table with a memory responder, scoreboard queue, and hand-written corner sequences.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [15:0] in_result, in_wdata;
   logic        in_mem_read, in_mem_write, in_mem_byte;
   logic [15:0] dmem_address, dmem_wdata, dmem_rdata;
   logic        dmem_read, dmem_write, dmem_resp;
   logic [1:0]  dmem_byte_enable;
   logic        out_valid, out_ready, out_err;
   logic [15:0] out_data;

   int n_total = 0;
   int n_pass  = 0;
   logic [16:0] exp_q[$];   // {data, err}

   typedef struct {
      logic [15:0] result;
      logic [15:0] wdata;
      logic        rd;
      logic        wr;
      logic        byt;
      int          wait_cyc;     // response on this request cycle; -1 = never
      logic [15:0] rdata;
      logic [15:0] exp_addr;
      logic [1:0]  exp_be;
      int          exp_req_cycles;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[11];

   mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_wdata(in_wdata),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_byte(in_mem_byte),
      .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic pop_chk(input string name);
      logic [16:0] e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL %s: output with empty scoreboard", name);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_valid"}, 32'(out_valid), 32'd1);
         chk({name, "_data"}, 32'(out_data), 32'(e[16:1]));
         chk({name, "_err"}, 32'(out_err), 32'(e[0]));
      end
   endtask

   task automatic clear_inputs();
      in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_mem_byte = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int held;
      string nm;
      nm = $sformatf("v%0d", idx);
      @(negedge clk);
      in_result = v.result; in_wdata = v.wdata;
      in_mem_read = v.rd; in_mem_write = v.wr; in_mem_byte = v.byt;
      in_valid = 1'b1;
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      exp_q.push_back({v.exp_data, v.exp_err});
      @(posedge clk);
      #1 clear_inputs();
      held = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!(dmem_read || dmem_write)) break;
         if (held == 0) begin
            chk({nm, "_addr"}, 32'(dmem_address), 32'(v.exp_addr));
            chk({nm, "_be"}, 32'(dmem_byte_enable), 32'(v.exp_be));
            chk({nm, "_dir"}, 32'({dmem_read, dmem_write}), 32'({v.rd, v.wr}));
            if (v.wr) chk({nm, "_wdata"}, 32'(dmem_wdata), 32'(v.wdata));
         end
         chk({nm, "_busy_in_ready"}, 32'(in_ready), 32'd0);
         held++;
         if (c == v.wait_cyc) begin
            dmem_resp = 1'b1; dmem_rdata = v.rdata;
         end
         @(posedge clk);
         #1 dmem_resp = 1'b0;
      end
      chk({nm, "_req_cycles"}, 32'(held), 32'(v.exp_req_cycles));
      pop_chk(nm);
   endtask

   initial begin
      //          result    wdata    rd wr by wait rdata    addr     be     cyc data     err
      vecs[0]  = '{16'h1234, 16'h0000, 0, 0, 0, -1, 16'h0000, 16'h0000, 2'b00, 0, 16'h1234, 0};
      vecs[1]  = '{16'h3001, 16'h0000, 1, 0, 1,  3, 16'hABCD, 16'h3000, 2'b10, 4, 16'h00AB, 0};
      vecs[2]  = '{16'h3000, 16'h0000, 1, 0, 1,  0, 16'hABCD, 16'h3000, 2'b01, 1, 16'h00CD, 0};
      vecs[3]  = '{16'h0041, 16'h5500, 0, 1, 1,  1, 16'h0000, 16'h0040, 2'b10, 2, 16'h0041, 0};
      vecs[4]  = '{16'h0042, 16'h1357, 0, 1, 0,  2, 16'h0000, 16'h0042, 2'b11, 3, 16'h0042, 0};
      vecs[5]  = '{16'h0005, 16'h0000, 1, 0, 0, -1, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1};
      vecs[6]  = '{16'h0010, 16'h0000, 1, 0, 0, -1, 16'h0000, 16'h0010, 2'b11, 4, 16'h0000, 1};
      vecs[7]  = '{16'h0010, 16'h0000, 1, 0, 0,  3, 16'hBEEF, 16'h0010, 2'b11, 4, 16'hBEEF, 0};
      vecs[8]  = '{16'h0007, 16'h9999, 0, 1, 0, -1, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1};
      vecs[9]  = '{16'h0020, 16'h0000, 1, 0, 0,  0, 16'h8001, 16'h0020, 2'b11, 1, 16'h8001, 0};
      vecs[10] = '{16'h0040, 16'h0066, 0, 1, 1,  0, 16'h0000, 16'h0040, 2'b01, 1, 16'h0040, 0};

      reset = 1'b1; out_ready = 1'b1; dmem_resp = 1'b0; dmem_rdata = 16'h0000;
      in_result = 16'h0000; in_wdata = 16'h0000;
      clear_inputs();
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_dmem", 32'({dmem_read, dmem_write, dmem_byte_enable, dmem_address, dmem_wdata}), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Back-to-back non-memory ops retire one per cycle.
      @(negedge clk);
      in_valid = 1'b1; in_result = 16'h1111;
      chk("b2b_in_ready0", 32'(in_ready), 32'd1);
      exp_q.push_back({16'h1111, 1'b0});
      @(negedge clk);
      pop_chk("b2b0");
      in_result = 16'h2222;
      chk("b2b_in_ready1", 32'(in_ready), 32'd1);
      exp_q.push_back({16'h2222, 1'b0});
      @(negedge clk);
      pop_chk("b2b1");
      in_result = 16'h3333;
      exp_q.push_back({16'h3333, 1'b0});
      @(negedge clk);
      pop_chk("b2b2");
      in_valid = 1'b0;

      // Backpressure: result held, no accept, then simultaneous consume and load.
      @(negedge clk);
      out_ready = 1'b0; in_result = 16'hA5A5; in_valid = 1'b1;
      chk("bp_in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back({16'hA5A5, 1'b0});
      @(posedge clk);
      #1 in_result = 16'h5A5A;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_data", 32'(out_data), 32'hA5A5);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      exp_q.push_back({16'h5A5A, 1'b0});
      pop_chk("bp_first");
      @(negedge clk);
      pop_chk("bp_second");
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_drain_valid", 32'(out_valid), 32'd0);

      // A response while idle must not produce a result.
      @(negedge clk);
      dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
      @(posedge clk);
      #1 dmem_resp = 1'b0;
      @(negedge clk);
      chk("idle_resp_valid", 32'(out_valid), 32'd0);
      chk("idle_resp_in_ready", 32'(in_ready), 32'd1);

      // Reset in the middle of an access drops it immediately.
      @(negedge clk);
      in_result = 16'h0100; in_mem_read = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 clear_inputs();
      @(negedge clk);
      chk("mid_rst_pre_read", 32'(dmem_read), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_read", 32'(dmem_read), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      run_vec(11, vecs[9]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
